// File: rtl/ssv_pkg.sv
// Shared constants and loader state encoding for the Gaussian-filter pipeline.
// Latency: n/a. Backpressure: n/a.
package ssv_pkg;

    localparam int IMG_ROWS = 12;
    localparam int IMG_COLS = 12;
    localparam int PIX_W    = 8;

    // Exposed here so the filter control can decode the loader state.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT
    } loader_state_t;

    // Address width that stays at least one bit for degenerate 1-pixel dimensions.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_counter.sv
// Raster row/col position counter; clr restarts at (0,0), inc advances one pixel.
// Latency: position updates on the clock edge after inc/clr. Backpressure: none, driven by the loader.
// Note: clr together with inc lands on the position following (0,0).
module rc_counter #(
    parameter int ROWS = 12,
    parameter int COLS = 12,
    parameter int RW   = 4,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] base_row;
    logic [CW-1:0] base_col;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] col_nxt;

    always_comb begin
        base_row = clr ? '0 : row;
        base_col = clr ? '0 : col;
        row_nxt  = base_row;
        col_nxt  = base_col;
        if (inc) begin
            if (base_col == COL_MAX) begin
                col_nxt = '0;
                row_nxt = (base_row == ROW_MAX) ? '0 : base_row + 1'b1;
            end else begin
                col_nxt = base_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (inc || clr) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/pixel_frame_loader.sv
// Writes one raster frame into the image BRAM, then kicks the filter; CHECKSUM_EN adds frame_sum.
// Latency: beat accepted at edge N is written in cycle N+1; start_p the cycle after the last write.
// Backpressure: s_ready low from the cycle after the last beat until filt_done is seen.
module pixel_frame_loader #(
    parameter int ROWS  = ssv_pkg::IMG_ROWS,
    parameter int COLS  = ssv_pkg::IMG_COLS,
    parameter int PIX_W = ssv_pkg::PIX_W,
    parameter int RW    = ssv_pkg::addr_w(ROWS),
    parameter int CW    = ssv_pkg::addr_w(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [PIX_W-1:0] s_data,
    output logic             wr_en,
    output logic [RW-1:0]    wr_row,
    output logic [CW-1:0]    wr_col,
    output logic [PIX_W-1:0] wr_data,
    output logic             start_p,
    input  logic             filt_done,
    output logic             busy,
    output logic             sof_err
`ifdef CHECKSUM_EN
    ,
    output logic [PIX_W+$clog2(ROWS*COLS)-1:0] frame_sum
`endif
);

    import ssv_pkg::*;

    localparam bit ONE_PIXEL = (ROWS == 1) && (COLS == 1);

    loader_state_t state;
    logic          beat;
    logic          take_sof;
    logic          take_pix;
    logic          cnt_last;
    logic [RW-1:0] cnt_row;
    logic [CW-1:0] cnt_col;

    assign s_ready  = (state == IDLE) || (state == LOAD);
    assign busy     = (state != IDLE);
    assign beat     = s_valid && s_ready;
    // An sof beat always (re)starts the frame at the origin, whatever the state.
    assign take_sof = beat && s_sof;
    assign take_pix = beat && !s_sof && (state == LOAD);

    rc_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_rc_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (take_sof || take_pix),
        .clr  (take_sof),
        .row  (cnt_row),
        .col  (cnt_col),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            start_p <= 1'b0;
            sof_err <= 1'b0;
        end else begin
            wr_en   <= take_sof || take_pix;
            start_p <= 1'b0;
            sof_err <= 1'b0;
            if (take_sof || take_pix) begin
                wr_row  <= take_sof ? '0 : cnt_row;
                wr_col  <= take_sof ? '0 : cnt_col;
                wr_data <= s_data;
            end
            case (state)
                IDLE: begin
                    if (beat) begin
                        if (s_sof) state <= ONE_PIXEL ? KICK : LOAD;
                        else       sof_err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        if (s_sof)         sof_err <= 1'b1;
                        else if (cnt_last) state   <= KICK;
                    end
                end
                KICK: begin
                    start_p <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (filt_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    localparam int SUM_W = PIX_W + $clog2(ROWS * COLS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_sum <= '0;
        end else if (take_sof) begin
            frame_sum <= SUM_W'(s_data);
        end else if (take_pix) begin
            frame_sum <= frame_sum + SUM_W'(s_data);
        end
    end
`endif

endmodule
